// File: rtl/hdmi_timing_pkg.sv
// Shared raster timing constants and types.
// Default mode is 640x480@60 (800x525 total).
package hdmi_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam bit SYNC_NEG = 1'b0;
   localparam bit SYNC_POS = 1'b1;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
   } ctrl_t;

   function automatic int span_total(
      input int act,
      input int fp,
      input int sync,
      input int bp
   );
      return act + fp + sync + bp;
   endfunction

   function automatic ctrl_t ctrl_idle(input bit pol);
      ctrl_t c;
      c.de = 1'b0;
      c.hs = ~pol;
      c.vs = ~pol;
      c.ls = 1'b0;
      c.fs = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// Scan position and control bundle going to the
// drawing stage and the TMDS encoders.
interface hdmi_timing_gen_if;

   logic [9:0] CounterX;
   logic [9:0] CounterY;
   logic       draw_area;
   logic       hsync;
   logic       vsync;
   logic       line_start;
   logic       frame_start;

   modport master (
      output CounterX,
      output CounterY,
      output draw_area,
      output hsync,
      output vsync,
      output line_start,
      output frame_start
   );

   modport slave (
      input CounterX,
      input CounterY,
      input draw_area,
      input hsync,
      input vsync,
      input line_start,
      input frame_start
   );

endinterface

// File: rtl/video_delay_line.sv
// Enable-gated shift register used to align video
// control/data with registered downstream stages.
module video_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("video_delay_line: DEPTH must be >= 1");
   end

   logic [DEPTH-1:0][WIDTH-1:0] sr;

   // shift one stage per enabled edge, all stages reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= {DEPTH{RST_VAL}};
      end else if (en) begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster scan counters plus delayed sync/blank
// decode aligned to the registered drawing stage.
module hdmi_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = SYNC_NEG,
   parameter int PIPE_DLY = 1
) (
   input  logic              pixclk,
   input  logic              rst_n,
   input  logic              en,
   hdmi_timing_gen_if.master vid
);

   localparam int H_TOTAL =
      span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL =
      span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("hdmi_timing_gen: total exceeds 1024");
   end
   if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
      $error("hdmi_timing_gen: PIPE_DLY not in 1..8");
   end

   localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

   // 11-bit bounds so a full 1024 span still compares
   localparam logic [10:0] HA  = 11'(H_ACTIVE);
   localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VA  = 11'(V_ACTIVE);
   localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  cx;
   logic [9:0]  cy;
   logic [10:0] x11;
   logic [10:0] y11;
   ctrl_t       dec;
   ctrl_t       q;

   // scan counters: X every enabled edge, Y on X wrap
   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         cx <= '0;
         cy <= '0;
      end else if (en) begin
         if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
               cy <= '0;
            end else begin
               cy <= cy + 10'd1;
            end
         end else begin
            cx <= cx + 10'd1;
         end
      end
   end

   assign x11 = {1'b0, cx};
   assign y11 = {1'b0, cy};

   // decode current position into the control bundle
   always_comb begin
      dec    = '0;
      dec.de = (x11 < HA) && (y11 < VA);
      dec.hs = (x11 >= HS0 && x11 < HS1) ?
               SYNC_POL : ~SYNC_POL;
      dec.vs = (y11 >= VS0 && y11 < VS1) ?
               SYNC_POL : ~SYNC_POL;
      dec.ls = (cx == 10'd0);
      dec.fs = (cx == 10'd0) && (cy == 10'd0);
   end

   video_delay_line #(
      .WIDTH   ($bits(ctrl_t)),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (ctrl_idle(SYNC_POL))
   ) u_dly (
      .clk   (pixclk),
      .rst_n (rst_n),
      .en    (en),
      .din   (dec),
      .dout  (q)
   );

   assign vid.CounterX    = cx;
   assign vid.CounterY    = cy;
   assign vid.draw_area   = q.de;
   assign vid.hsync       = q.hs;
   assign vid.vsync       = q.vs;
   assign vid.line_start  = q.ls;
   assign vid.frame_start = q.fs;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench: default 640x480 instance plus a
// tiny 16x10 active-high, 3-deep instance.
module tb_hdmi_timing_gen;

   logic pixclk = 1'b0;
   logic rst_n  = 1'b0;
   logic en     = 1'b0;
   int   cyc;
   int   nerr;
   int   nchk;

   hdmi_timing_gen_if v1 ();
   hdmi_timing_gen_if v2 ();

   hdmi_timing_gen u_dut1 (
      .pixclk (pixclk),
      .rst_n  (rst_n),
      .en     (en),
      .vid    (v1.master)
   );

   hdmi_timing_gen #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (3),
      .V_ACTIVE (6),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1),
      .SYNC_POL (1'b1),
      .PIPE_DLY (3)
   ) u_dut2 (
      .pixclk (pixclk),
      .rst_n  (rst_n),
      .en     (en),
      .vid    (v2.master)
   );

   always #5 pixclk = ~pixclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge pixclk);
      if (en) cyc++;
   endtask

   task automatic test_reset();
      en    = 1'b1;
      rst_n = 1'b0;
      repeat (10) @(negedge pixclk);
      nchk++;
      if (v1.CounterX !== 10'd0 || v1.CounterY !== 10'd0) begin
         nerr++;
         $display("FAIL rst_xy: got %0d,%0d want 0,0",
                  v1.CounterX, v1.CounterY);
      end
      nchk++;
      if (v1.draw_area !== 1'b0 || v1.frame_start !== 1'b0
          || v1.line_start !== 1'b0) begin
         nerr++;
         $display("FAIL rst_pulse: de=%b fs=%b ls=%b want 0",
                  v1.draw_area, v1.frame_start, v1.line_start);
      end
      nchk++;
      if (v1.hsync !== 1'b1 || v1.vsync !== 1'b1) begin
         nerr++;
         $display("FAIL rst_sync: hs=%b vs=%b want 1,1",
                  v1.hsync, v1.vsync);
      end
      nchk++;
      if (v2.hsync !== 1'b0 || v2.vsync !== 1'b0) begin
         nerr++;
         $display("FAIL rst_sync2: hs=%b vs=%b want 0,0",
                  v2.hsync, v2.vsync);
      end
      rst_n = 1'b1;
      cyc   = 0;
      step();
      nchk++;
      if (v1.CounterX !== 10'd1 || v1.CounterY !== 10'd0) begin
         nerr++;
         $display("FAIL rel_xy: got %0d,%0d want 1,0",
                  v1.CounterX, v1.CounterY);
      end
      nchk++;
      if (v1.draw_area !== 1'b1 || v1.line_start !== 1'b1
          || v1.frame_start !== 1'b1) begin
         nerr++;
         $display("FAIL rel_ctl: de=%b ls=%b fs=%b want 1",
                  v1.draw_area, v1.line_start, v1.frame_start);
      end
      nchk++;
      if (v2.CounterX !== 10'd1 || v2.draw_area !== 1'b0
          || v2.frame_start !== 1'b0) begin
         nerr++;
         $display("FAIL rel2: x=%0d de=%b fs=%b want 1,0,0",
                  v2.CounterX, v2.draw_area, v2.frame_start);
      end
   endtask

   task automatic test_line0();
      int dcnt = 0, dfirst = -1, dlast = -1;
      int hcnt = 0, hfirst = -1, hlast = -1;
      int lcnt = 0;
      int d;
      for (int i = 0; i < 800; i++) begin
         if (i > 0) step();
         d = cyc - 1;
         nchk++;
         if (v1.CounterX !== 10'(cyc % 800)) begin
            nerr++;
            $display("FAIL line_x: got %0d want %0d",
                     v1.CounterX, cyc % 800);
         end
         if (v1.draw_area) begin
            dcnt++;
            if (dfirst < 0) dfirst = d;
            dlast = d;
         end
         if (!v1.hsync) begin
            hcnt++;
            if (hfirst < 0) hfirst = d;
            hlast = d;
         end
         if (v1.line_start) lcnt++;
         if (cyc == 799) begin
            nchk++;
            if (v1.CounterY !== 10'd0) begin
               nerr++;
               $display("FAIL pre_wrap_y: got %0d want 0",
                        v1.CounterY);
            end
         end
         if (cyc == 800) begin
            nchk++;
            if (v1.CounterY !== 10'd1) begin
               nerr++;
               $display("FAIL wrap_y: got %0d want 1",
                        v1.CounterY);
            end
         end
      end
      nchk++;
      if (dcnt !== 640 || dfirst !== 0 || dlast !== 639) begin
         nerr++;
         $display("FAIL line_de: n=%0d %0d..%0d want 640 0..639",
                  dcnt, dfirst, dlast);
      end
      nchk++;
      if (hcnt !== 96 || hfirst !== 656 || hlast !== 751) begin
         nerr++;
         $display("FAIL line_hs: n=%0d %0d..%0d want 96 656..751",
                  hcnt, hfirst, hlast);
      end
      nchk++;
      if (lcnt !== 1) begin
         nerr++;
         $display("FAIL line_ls: got %0d want 1", lcnt);
      end
   endtask

   task automatic test_en_hold();
      int dcnt = 0, lcnt = 0;
      while (cyc < 801) step();
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         nchk++;
         if (v1.CounterX !== 10'd1 || v1.line_start !== 1'b1) begin
            nerr++;
            $display("FAIL hold_ls: x=%0d ls=%b want 1,1",
                     v1.CounterX, v1.line_start);
         end
      end
      en = 1'b1;
      step();
      nchk++;
      if (v1.CounterX !== 10'd2 || v1.line_start !== 1'b0) begin
         nerr++;
         $display("FAIL resume_ls: x=%0d ls=%b want 2,0",
                  v1.CounterX, v1.line_start);
      end
      while (cyc < 1440) step();
      nchk++;
      if (v1.CounterX !== 10'd640 || v1.draw_area !== 1'b1) begin
         nerr++;
         $display("FAIL at640: x=%0d de=%b want 640,1",
                  v1.CounterX, v1.draw_area);
      end
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         nchk++;
         if (v1.CounterX !== 10'd640 || v1.draw_area !== 1'b1) begin
            nerr++;
            $display("FAIL hold_de: x=%0d de=%b want 640,1",
                     v1.CounterX, v1.draw_area);
         end
         nchk++;
         if (v2.CounterX !== 10'(cyc % 16)) begin
            nerr++;
            $display("FAIL hold_x2: got %0d want %0d",
                     v2.CounterX, cyc % 16);
         end
      end
      en = 1'b1;
      step();
      nchk++;
      if (v1.CounterX !== 10'd641 || v1.draw_area !== 1'b0) begin
         nerr++;
         $display("FAIL fall_de: x=%0d de=%b want 641,0",
                  v1.CounterX, v1.draw_area);
      end
      for (int i = 0; i < 800; i++) begin
         step();
         if (v1.draw_area) dcnt++;
         if (v1.line_start) lcnt++;
      end
      nchk++;
      if (dcnt !== 640 || lcnt !== 1) begin
         nerr++;
         $display("FAIL after_hold: de=%0d ls=%0d want 640,1",
                  dcnt, lcnt);
      end
   endtask

   task automatic test_frame_small();
      int dcnt = 0, hcnt = 0, vcnt = 0;
      int run = 0, maxrun = 0;
      int fcnt = 0, lcnt = 0, f0 = -1, f1 = -1;
      bit vprev;
      vprev = v2.vsync;
      for (int i = 0; i < 320; i++) begin
         step();
         nchk++;
         if (v2.CounterX !== 10'(cyc % 16)
             || v2.CounterY !== 10'((cyc / 16) % 10)) begin
            nerr++;
            $display("FAIL sm_xy: got %0d,%0d want %0d,%0d",
                     v2.CounterX, v2.CounterY,
                     cyc % 16, (cyc / 16) % 10);
         end
         if (v2.draw_area) dcnt++;
         if (v2.hsync) hcnt++;
         if (v2.line_start) lcnt++;
         if (v2.vsync) begin
            vcnt++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         if (v2.vsync && !vprev) begin
            nchk++;
            if ((cyc - 3) % 160 !== 112) begin
               nerr++;
               $display("FAIL sm_vs_rise: phase %0d want 112",
                        (cyc - 3) % 160);
            end
         end
         vprev = v2.vsync;
         if (v2.frame_start) begin
            fcnt++;
            if (f0 < 0) f0 = cyc;
            else f1 = cyc;
            nchk++;
            if ((cyc - 3) % 160 !== 0) begin
               nerr++;
               $display("FAIL sm_fs_phase: got %0d want 0",
                        (cyc - 3) % 160);
            end
         end
      end
      nchk++;
      if (dcnt !== 96 || hcnt !== 60 || lcnt !== 20) begin
         nerr++;
         $display("FAIL sm_cnt: de=%0d hs=%0d ls=%0d want 96,60,20",
                  dcnt, hcnt, lcnt);
      end
      nchk++;
      if (vcnt !== 64 || maxrun !== 32) begin
         nerr++;
         $display("FAIL sm_vs: n=%0d run=%0d want 64,32",
                  vcnt, maxrun);
      end
      nchk++;
      if (fcnt !== 2 || f1 - f0 !== 160) begin
         nerr++;
         $display("FAIL sm_fs: n=%0d gap=%0d want 2,160",
                  fcnt, f1 - f0);
      end
   endtask

   task automatic test_mid_reset();
      while (cyc % 800 != 701) step();
      nchk++;
      if (v1.hsync !== 1'b0 || v2.hsync !== 1'b1) begin
         nerr++;
         $display("FAIL pre_rst_hs: %b,%b want 0,1",
                  v1.hsync, v2.hsync);
      end
      #2 rst_n = 1'b0;
      #1;
      nchk++;
      if (v1.hsync !== 1'b1 || v1.vsync !== 1'b1
          || v2.hsync !== 1'b0) begin
         nerr++;
         $display("FAIL async_hs: %b,%b,%b want 1,1,0",
                  v1.hsync, v1.vsync, v2.hsync);
      end
      nchk++;
      if (v1.CounterX !== 10'd0 || v1.CounterY !== 10'd0
          || v1.draw_area !== 1'b0) begin
         nerr++;
         $display("FAIL async_xy: %0d,%0d de=%b want 0,0,0",
                  v1.CounterX, v1.CounterY, v1.draw_area);
      end
      repeat (2) @(negedge pixclk);
      rst_n = 1'b1;
      cyc   = 0;
      step();
      nchk++;
      if (v1.CounterX !== 10'd1 || v1.CounterY !== 10'd0
          || v1.frame_start !== 1'b1) begin
         nerr++;
         $display("FAIL restart: %0d,%0d fs=%b want 1,0,1",
                  v1.CounterX, v1.CounterY, v1.frame_start);
      end
      while (cyc < 126) step();
      nchk++;
      if (v2.vsync !== 1'b1 || v2.hsync !== 1'b1
          || v2.CounterY !== 10'd7) begin
         nerr++;
         $display("FAIL pre_rst_vs: vs=%b hs=%b y=%0d want 1,1,7",
                  v2.vsync, v2.hsync, v2.CounterY);
      end
      #2 rst_n = 1'b0;
      #1;
      nchk++;
      if (v2.vsync !== 1'b0 || v2.hsync !== 1'b0
          || v2.CounterX !== 10'd0 || v2.CounterY !== 10'd0) begin
         nerr++;
         $display("FAIL async2: vs=%b hs=%b %0d,%0d want 0,0,0,0",
                  v2.vsync, v2.hsync, v2.CounterX, v2.CounterY);
      end
      @(negedge pixclk);
      rst_n = 1'b1;
      cyc   = 0;
      step();
      step();
      nchk++;
      if (v2.CounterX !== 10'd2 || v2.frame_start !== 1'b0) begin
         nerr++;
         $display("FAIL dly2: x=%0d fs=%b want 2,0",
                  v2.CounterX, v2.frame_start);
      end
      step();
      nchk++;
      if (v2.frame_start !== 1'b1 || v2.line_start !== 1'b1
          || v2.draw_area !== 1'b1 || v2.vsync !== 1'b0) begin
         nerr++;
         $display("FAIL dly3: fs=%b ls=%b de=%b vs=%b want 1,1,1,0",
                  v2.frame_start, v2.line_start,
                  v2.draw_area, v2.vsync);
      end
   endtask

   initial begin
      nerr = 0;
      nchk = 0;
      cyc  = 0;
      test_reset();
      test_line0();
      test_en_hold();
      test_frame_small();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/hdmi_timing_gen.md
Name: hdmi_timing_gen

Overview:
Raster timing generator that sits directly upstream of the pattern/frame drawing stage and the TMDS encoders. It produces the 10-bit CounterX/CounterY scan position and the hsync, vsync and draw_area control signals. The control outputs are delayed so they arrive aligned with pixel data from the registered drawing stage. Default timing is 640x480@60 (800x525 total, 25.175 MHz pixclk).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high
PIPE_DLY, 1, cycles between a counter value and its decoded control outputs; range 1..8

Ports:
pixclk  input  1  pixel clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; when low, all state holds
CounterX  output  10  horizontal position, 0..H_TOTAL-1
CounterY  output  10  vertical position, 0..V_TOTAL-1
draw_area  output  1  visible pixel, delayed PIPE_DLY cycles
hsync  output  1  horizontal sync, polarity per SYNC_POL, delayed PIPE_DLY cycles
vsync  output  1  vertical sync, polarity per SYNC_POL, delayed PIPE_DLY cycles
line_start  output  1  one-cycle pulse for CounterX==0, delayed PIPE_DLY cycles
frame_start  output  1  one-cycle pulse for CounterX==0 && CounterY==0, delayed PIPE_DLY cycles

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration error if H_TOTAL > 1024, V_TOTAL > 1024, or PIPE_DLY is outside 1..8.
- Reset (rst_n low, asynchronous):
  - CounterX = 0, CounterY = 0.
  - draw_area = 0, line_start = 0, frame_start = 0.
  - hsync = vsync = inactive level (~SYNC_POL).
  - Every delay-pipe stage is cleared to these same inactive values.
- Reset release: the first enabled edge after rst_n rises produces CounterX = 1. The counter value 0,0 is present from reset itself.
- Counters, on each pixclk edge with en = 1:
  - CounterX increments by 1; at H_TOTAL-1 it wraps to 0.
  - CounterY increments only on the X wrap; at V_TOTAL-1 with X wrapping, it wraps to 0.
  - No other CounterY changes occur.
- Decode, combinational on the current counters:
  - de = (X < H_ACTIVE) && (Y < V_ACTIVE).
  - hs = H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC. vsync changes on the X wrap edge, i.e. it is line-aligned.
  - ls = (X == 0).
  - fs = (X == 0 && Y == 0).
- Output pipe:
  - {de, hs^~SYNC_POL, vs^~SYNC_POL, ls, fs} passes through a PIPE_DLY-stage shift register that advances only when en = 1.
  - Outputs show the decode of the counter value from PIPE_DLY enabled cycles earlier.
  - With PIPE_DLY = 1, control outputs align with a downstream stage that registers colour once from CounterX/CounterY.
- en = 0: counters and every pipe stage hold their values; no pulse is generated or lost. A pulse held during en = 0 stays high until the next enabled edge.
- Reset mid-frame: immediate return to reset values. No partial sync pulse is stretched; hsync/vsync go inactive asynchronously.
- Per frame (en held high):
  - draw_area is high for exactly H_ACTIVE*V_ACTIVE cycles.
  - hsync is active H_SYNC cycles per line.
  - vsync is active V_SYNC*H_TOTAL cycles.
  - frame_start fires once every H_TOTAL*V_TOTAL cycles.

Decomposition:
- Package hdmi_timing_pkg:
  - default 640x480@60 constants (H_/V_ ACTIVE, FP, SYNC, BP);
  - H_TOTAL/V_TOTAL helper function;
  - SYNC_NEG/SYNC_POS polarity constants;
  - a packed struct type for the 5-bit control bundle.
- Sub-module video_delay_line: WIDTH- and DEPTH-parameterised, enable-gated shift register. It takes an asynchronous active-low reset and a reset-value parameter. It is reusable downstream for aligning data to the TMDS stage.

Test Plan:
- Reset held low 10 cycles, then released -> CounterX/CounterY = 0, draw_area = 0, hsync = vsync = 1, frame_start = 0; the first enabled edge gives CounterX = 1.
- Run line 0 with en high -> draw_area high for 640 cycles starting 1 cycle after X = 0. hsync is low when the delayed X is 656..751 (96 cycles). line_start pulses once per 800 cycles.
- Step X from 799 to 0 -> CounterY increments 0 to 1 on the same edge. At Y = 524, X = 799 the next edge gives Y = 0, and frame_start pulses 1 cycle later. The period is exactly 420000 cycles.
- vsync check over one frame -> low for 2 lines (Y = 490..491 delayed), i.e. 1600 consecutive cycles, aligned to the X wrap. draw_area high count is 307200.
- en toggled 1-0-0-1 around X = 639/640 -> counters and draw_area hold during the low cycles. draw_area falls only after the enabled edge that advances past X = 639. No missing or duplicated pulses.
- rst_n asserted at X = 700, Y = 490 (inside hsync and vsync) -> same-cycle asynchronous return: hsync = vsync = 1, counters = 0. After release the sequence restarts cleanly from 0,0. Repeat with SYNC_POL = 1 and PIPE_DLY = 3 to check inverted polarity and a 3-cycle offset.
